fsb_master: RTL

Synchronous MC68000-style bus initiator. It turns single-word requests from internal logic (DMA, test/bring-up engine) into asynchronous front-side-bus cycles: it drives address, nAS, nUDS/nLDS and RnW, then waits for termination by nDTACK, by nVPA (6800-style synchronous cycle on E), or by nBERR. It is the initiator counterpart to the board's existing DTACK/VPA responder and sits between the internal request port and the FSB pins.

---
 rtl/fsb_master_if.sv | 26 ++
 rtl/fsb_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fsb_master_if.sv
// Front-side-bus pin bundle between the bus initiator and the board responder.
interface fsb_master_if;
  logic [22:0] A;
  logic [15:0] Dout;
  logic        Doe;
  logic [15:0] Din;
  logic        nAS;
  logic        nUDS;
  logic        nLDS;
  logic        RnW;
  logic        nVMA;
  logic        E;
  logic        nDTACK;
  logic        nVPA;
  logic        nBERR;

  modport master (
    output A, Dout, Doe, nAS, nUDS, nLDS, RnW, nVMA, E,
    input  Din, nDTACK, nVPA, nBERR
  );

  modport slave (
    input  A, Dout, Doe, nAS, nUDS, nLDS, RnW, nVMA, E,
    output Din, nDTACK, nVPA, nBERR
  );
endinterface

// File: rtl/fsb_master.sv
// MC68000-style bus initiator: turns single-word internal requests into
// asynchronous FSB cycles terminated by nDTACK, nVPA/E or nBERR.
module fsb_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               FCLK,
  input  logic               nRST,
  input  logic               Req,
  input  logic               Write,
  input  logic [22:0]        Addr,
  input  logic [1:0]         BE,
  input  logic [15:0]        WData,
  output logic               Busy,
  output logic               Ack,
  output logic               Err,
  output logic [15:0]        RData,
  fsb_master_if.master       fsb
);

  localparam int unsigned WD_W   = $clog2(TIMEOUT);
  localparam int unsigned ECNT_W = 4;
  localparam logic [ECNT_W-1:0] E_LAST = ECNT_W'(9);
  localparam logic [ECNT_W-1:0] E_PRE  = ECNT_W'(5);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ASRT, WAIT, DATA, VPASYNC, VMA, TERM, RECOV
  } state_t;

  state_t            state;
  logic              wr_q;
  logic [1:0]        be_q;
  logic [WD_W-1:0]   wd;
  logic [ECNT_W-1:0] ecnt;

  // Free-running 6800 E clock: count 0..9, high for counts 6..9.
  always_ff @(posedge FCLK) begin
    if (!nRST) begin
      ecnt  <= '0;
      fsb.E <= 1'b0;
    end else if (ecnt == E_LAST) begin
      ecnt  <= '0;
      fsb.E <= 1'b0;
    end else begin
      ecnt  <= ecnt + ECNT_W'(1);
      fsb.E <= (ecnt >= E_PRE);
    end
  end

  // Bus-cycle sequencer; pin values are registered together with the state they belong to.
  always_ff @(posedge FCLK) begin
    if (!nRST) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      be_q     <= 2'b11;
      wd       <= '0;
      Busy     <= 1'b0;
      Ack      <= 1'b0;
      Err      <= 1'b0;
      RData    <= '0;
      fsb.A    <= '0;
      fsb.Dout <= '0;
      fsb.Doe  <= 1'b0;
      fsb.nAS  <= 1'b1;
      fsb.nUDS <= 1'b1;
      fsb.nLDS <= 1'b1;
      fsb.RnW  <= 1'b1;
      fsb.nVMA <= 1'b1;
    end else begin
      Ack <= 1'b0;
      Err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Req) begin
            wr_q     <= Write;
            be_q     <= (BE == 2'b00) ? 2'b11 : BE;
            wd       <= '0;
            fsb.A    <= Addr;
            fsb.Dout <= WData;
            fsb.Doe  <= Write;
            fsb.RnW  <= ~Write;
            Busy     <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          fsb.nAS <= 1'b0;
          if (!wr_q) begin
            fsb.nUDS <= ~be_q[1];
            fsb.nLDS <= ~be_q[0];
          end
          state <= ASRT;
        end
        ASRT: begin
          fsb.nUDS <= ~be_q[1];
          fsb.nLDS <= ~be_q[0];
          state    <= WAIT;
        end
        WAIT: begin
          if (!fsb.nBERR || (fsb.nDTACK && fsb.nVPA && (wd == WD_LAST))) begin
            // Bus error or watchdog expiry both end the cycle with Err.
            fsb.nAS  <= 1'b1;
            fsb.nUDS <= 1'b1;
            fsb.nLDS <= 1'b1;
            fsb.nVMA <= 1'b1;
            Ack      <= 1'b1;
            Err      <= 1'b1;
            state    <= TERM;
          end else if (!fsb.nDTACK) begin
            state <= DATA;
          end else if (!fsb.nVPA) begin
            state <= VPASYNC;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        DATA: begin
          if (!wr_q) RData <= fsb.Din;
          fsb.nAS  <= 1'b1;
          fsb.nUDS <= 1'b1;
          fsb.nLDS <= 1'b1;
          fsb.nVMA <= 1'b1;
          Ack      <= 1'b1;
          state    <= TERM;
        end
        VPASYNC: begin
          if (!fsb.nBERR) begin
            fsb.nAS  <= 1'b1;
            fsb.nUDS <= 1'b1;
            fsb.nLDS <= 1'b1;
            fsb.nVMA <= 1'b1;
            Ack      <= 1'b1;
            Err      <= 1'b1;
            state    <= TERM;
          end else if (ecnt == E_PRE) begin
            // Enter VMA so nVMA goes low exactly as E rises.
            fsb.nVMA <= 1'b0;
            state    <= VMA;
          end
        end
        VMA: begin
          if (ecnt == E_LAST) begin
            if (!wr_q) RData <= fsb.Din;
            fsb.nAS  <= 1'b1;
            fsb.nUDS <= 1'b1;
            fsb.nLDS <= 1'b1;
            fsb.nVMA <= 1'b1;
            Ack      <= 1'b1;
            state    <= TERM;
          end
        end
        TERM: begin
          fsb.Doe <= 1'b0;
          fsb.RnW <= 1'b1;
          state   <= RECOV;
        end
        RECOV: begin
          if (fsb.nDTACK && fsb.nVPA && fsb.nBERR) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
